// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI mode-0 target transceiver.
package spi_target_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/spi_target_sync.sv
// Multi-stage synchroniser for one asynchronous SPI pin, plus a flop holding
// the previous synchronised value so single-cycle rise/fall strobes can be
// derived. RST_VAL sets the value the chain assumes during reset.
module spi_target_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    // Next value of the shift chain and the edge-detect history flop.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    // Synchroniser chain and previous-value register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target byte transceiver. The master's pins are oversampled in the
// clk domain; MOSI is deserialised into bytes and bytes from a one-entry
// transmit holding register are serialised onto MISO.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sck,
    input  logic              cs,
    input  logic              sdi,
    output logic              sdo,
    output logic              sdo_oe,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              frame_start,
    output logic              frame_end,
    output logic              underrun
);

    logic sck_rise_s, sck_fall_s, sck_lvl_s;
    logic cs_rise_s, cs_fall_s, cs_lvl_s;
    logic sdi_s;

    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;

    state_t              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-2:0]   rx_shift_q, rx_shift_d;
    logic [BYTE_W-1:0]   tx_shift_q, tx_shift_d;
    logic [BYTE_W-1:0]   hold_data_q, hold_data_d;
    logic                hold_full_q, hold_full_d;
    logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                frame_start_q, frame_start_d;
    logic                frame_end_q, frame_end_d;
    logic                underrun_q, underrun_d;
    logic                sdo_q, sdo_d;
    logic                sdo_oe_q, sdo_oe_d;

    logic byte_load_s;
    logic tx_shift_en_s;
    logic tx_accept_s;

    // sck idles low. cs resets low so that a cs already low when reset is
    // released produces no falling edge; a fresh fall is required to start.
    spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sck),
        .q       (sck_lvl_s),
        .rise    (sck_rise_s),
        .fall    (sck_fall_s)
    );

    spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (cs),
        .q       (cs_lvl_s),
        .rise    (cs_rise_s),
        .fall    (cs_fall_s)
    );

    // MOSI needs only the level, aligned with the sck edge-detect stage.
    always_comb begin
        sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    end

    assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];
    assign tx_accept_s = tx_valid & ~hold_full_q;

    // Frame sequencing, bit counting, shift registers and holding register.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        hold_data_d   = hold_data_q;
        hold_full_d   = hold_full_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        underrun_d    = 1'b0;
        byte_load_s   = 1'b0;
        tx_shift_en_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall_s) begin
                    state_d       = ACTIVE;
                    frame_start_d = 1'b1;
                    bit_cnt_d     = 3'd0;
                    byte_load_s   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                // cs edges win over sck edges seen in the same cycle; a
                // partial byte is simply dropped.
                if (cs_rise_s) begin
                    state_d     = IDLE;
                    frame_end_d = 1'b1;
                end else if (sck_rise_s) begin
                    rx_shift_d = {rx_shift_q[BYTE_W-3:0], sdi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {rx_shift_q, sdi_s};
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_valid_d = 1'b0;
                    end
                end else if (sck_fall_s) begin
                    if (bit_cnt_q != 3'd0) begin
                        tx_shift_en_s = 1'b1;
                    end else begin
                        byte_load_s = 1'b1;
                    end
                end else begin
                    state_d = ACTIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Byte slot: take the holding register, or send zeros and flag it.
        if (byte_load_s) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_data_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = 8'h00;
                underrun_d = 1'b1;
            end
        end else if (tx_shift_en_s) begin
            tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
        end else begin
            tx_shift_d = tx_shift_q;
        end

        // Accept is judged on the old fill state, so a same-cycle load and
        // handshake hands out the old byte and refills with the new one.
        if (tx_accept_s) begin
            hold_data_d = tx_data;
            hold_full_d = 1'b1;
        end else begin
            hold_data_d = hold_data_q;
        end

        sdo_oe_d = (state_q == ACTIVE);
        sdo_d    = (state_q == ACTIVE) ? tx_shift_q[BYTE_W-1] : 1'b0;
    end

    // State and datapath registers; reset aborts any frame with no pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sdi_sync_q    <= {SYNC_STAGES{1'b0}};
            state_q       <= IDLE;
            bit_cnt_q     <= 3'd0;
            rx_shift_q    <= 7'h00;
            tx_shift_q    <= 8'h00;
            hold_data_q   <= 8'h00;
            hold_full_q   <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            underrun_q    <= 1'b0;
            sdo_q         <= 1'b0;
            sdo_oe_q      <= 1'b0;
        end else begin
            sdi_sync_q    <= sdi_sync_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            hold_data_q   <= hold_data_d;
            hold_full_q   <= hold_full_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            underrun_q    <= underrun_d;
            sdo_q         <= sdo_d;
            sdo_oe_q      <= sdo_oe_d;
        end
    end

    assign sdo         = sdo_q;
    assign sdo_oe      = sdo_oe_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = ~hold_full_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign underrun    = underrun_q;

    // Synchronised levels are kept for debug visibility only.
    logic unused_lvl_s;
    assign unused_lvl_s = sck_lvl_s ^ cs_lvl_s;

endmodule

// File: tb/tb_spi_target.sv
// Directed testbench for spi_target: a behavioural mode-0 SPI master with
// sck half period of 8 clk cycles, plus pulse counters on the target outputs.
module tb_spi_target;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs = 1'b1;
    logic       sdi = 1'b0;
    logic       sdo, sdo_oe, rx_valid, tx_ready, frame_start, frame_end, underrun;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    int fs_cnt = 0, fe_cnt = 0, rv_cnt = 0, ur_cnt = 0, oe_cnt = 0;
    logic [7:0] rx_log [16];
    logic       ready_at_start = 1'b0;

    spi_target #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sck         (sck),
        .cs          (cs),
        .sdi         (sdi),
        .sdo         (sdo),
        .sdo_oe      (sdo_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // Count high cycles of every pulse output and log received bytes.
    always @(negedge clk) begin
        if (frame_start) begin
            fs_cnt         <= fs_cnt + 1;
            ready_at_start <= tx_ready;
        end
        if (frame_end) fe_cnt <= fe_cnt + 1;
        if (underrun)  ur_cnt <= ur_cnt + 1;
        if (sdo_oe)    oe_cnt <= oe_cnt + 1;
        if (rx_valid) begin
            rx_log[rv_cnt % 16] <= rx_data;
            rv_cnt              <= rv_cnt + 1;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic offer(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Master frame: byte k of mosi is bits [8k+7:8k], sent first-to-last,
    // MSB first. The last sck fall coincides with cs rising.
    task automatic spi_frame(input int nbits, input logic [31:0] mosi, output logic [31:0] miso);
        int idx;
        miso = 32'h0;
        @(negedge clk);
        cs = 1'b0;
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            idx = 8 * (i / 8) + 7 - (i % 8);
            sdi = mosi[idx];
            wait_clk(8);
            miso[idx] = sdo;
            sck = 1'b1;
            wait_clk(8);
            if (i != nbits - 1) sck = 1'b0;
        end
        sck = 1'b0;
        cs  = 1'b1;
        wait_clk(12);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(10);
        tests_run++;
        if ({sdo, sdo_oe, rx_data, rx_valid, tx_ready, frame_start, frame_end, underrun} !== 15'h0008) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected %h",
                     {sdo, sdo_oe, rx_data, rx_valid, tx_ready, frame_start, frame_end, underrun}, 15'h0008);
        end
        tests_run++;
        if (fs_cnt + fe_cnt + ur_cnt + rv_cnt !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_pulses: got %0d expected 0", fs_cnt + fe_cnt + ur_cnt + rv_cnt);
        end
    endtask

    task automatic test_single_byte;
        logic [31:0] m;
        int fs0 = fs_cnt, fe0 = fe_cnt, rv0 = rv_cnt, ur0 = ur_cnt, oe0 = oe_cnt;
        offer(8'hA5);
        tests_run++;
        if (tx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL preload_ready: got %b expected 0", tx_ready);
        end
        spi_frame(8, 32'h0000003C, m);
        tests_run++;
        if (m[7:0] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL single_miso: got %h expected a5", m[7:0]);
        end
        tests_run++;
        if (rv_cnt - rv0 !== 1 || rx_log[rv0 % 16] !== 8'h3C) begin
            tests_failed++;
            $display("FAIL single_rx: got %0d pulses data %h expected 1 pulse data 3c", rv_cnt - rv0, rx_log[rv0 % 16]);
        end
        tests_run++;
        if (fs_cnt - fs0 !== 1 || fe_cnt - fe0 !== 1 || ur_cnt - ur0 !== 0) begin
            tests_failed++;
            $display("FAIL single_pulses: got fs %0d fe %0d ur %0d expected 1 1 0", fs_cnt - fs0, fe_cnt - fe0, ur_cnt - ur0);
        end
        tests_run++;
        if (ready_at_start !== 1'b1 || oe_cnt == oe0) begin
            tests_failed++;
            $display("FAIL single_ready_oe: got ready %b oe_cycles %0d expected ready 1 oe_cycles >0", ready_at_start, oe_cnt - oe0);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] m;
        int rv0 = rv_cnt, ur0 = ur_cnt;
        offer(8'h12);
        fork
            spi_frame(16, 32'h0000ADDE, m);
            begin
                int n = 0;
                while (!tx_ready && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                tests_run++;
                if (!tx_ready) begin
                    tests_failed++;
                    $display("FAIL b2b_ready_timeout: got %b expected 1", tx_ready);
                end else begin
                    tx_data  = 8'h34;
                    tx_valid = 1'b1;
                    @(negedge clk);
                    tx_valid = 1'b0;
                end
            end
        join
        tests_run++;
        if (m[15:0] !== 16'h3412) begin
            tests_failed++;
            $display("FAIL b2b_miso: got %h expected 3412", m[15:0]);
        end
        tests_run++;
        if (rv_cnt - rv0 !== 2 || rx_log[rv0 % 16] !== 8'hDE || rx_log[(rv0 + 1) % 16] !== 8'hAD) begin
            tests_failed++;
            $display("FAIL b2b_rx: got %0d pulses %h %h expected 2 de ad",
                     rv_cnt - rv0, rx_log[rv0 % 16], rx_log[(rv0 + 1) % 16]);
        end
        tests_run++;
        if (ur_cnt - ur0 !== 0) begin
            tests_failed++;
            $display("FAIL b2b_underrun: got %0d expected 0", ur_cnt - ur0);
        end
    endtask

    task automatic test_underrun;
        logic [31:0] m;
        int ur0 = ur_cnt;
        spi_frame(16, 32'h00000F0F, m);
        tests_run++;
        if (m[15:0] !== 16'h0000 || ur_cnt - ur0 !== 2) begin
            tests_failed++;
            $display("FAIL underrun: got miso %h pulses %0d expected 0000 2", m[15:0], ur_cnt - ur0);
        end
    endtask

    task automatic test_abort;
        logic [31:0] m;
        int rv0 = rv_cnt, fe0 = fe_cnt;
        spi_frame(5, 32'h000000FF, m);
        tests_run++;
        if (rv_cnt - rv0 !== 0 || fe_cnt - fe0 !== 1) begin
            tests_failed++;
            $display("FAIL abort_partial: got rx %0d fe %0d expected 0 1", rv_cnt - rv0, fe_cnt - fe0);
        end
        spi_frame(8, 32'h00000081, m);
        tests_run++;
        if (rv_cnt - rv0 !== 1 || rx_data !== 8'h81) begin
            tests_failed++;
            $display("FAIL abort_next: got rx %0d data %h expected 1 81", rv_cnt - rv0, rx_data);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] m;
        int fs0;
        offer(8'hC3);
        @(negedge clk);
        cs = 1'b0;
        wait_clk(8);
        offer(8'h99);
        for (int i = 0; i < 3; i++) begin
            sdi = 1'b1;
            wait_clk(8);
            sck = 1'b1;
            wait_clk(8);
            sck = 1'b0;
        end
        wait_clk(4);
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({sdo, sdo_oe, rx_data, rx_valid, tx_ready, frame_start, frame_end, underrun} !== 15'h0008) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got %h expected %h",
                     {sdo, sdo_oe, rx_data, rx_valid, tx_ready, frame_start, frame_end, underrun}, 15'h0008);
        end
        wait_clk(3);
        fs0 = fs_cnt;
        reset_n = 1'b1;
        wait_clk(20);
        tests_run++;
        if (fs_cnt - fs0 !== 0 || sdo_oe !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_cs_low: got fs %0d oe %b expected 0 0", fs_cnt - fs0, sdo_oe);
        end
        cs = 1'b1;
        wait_clk(10);
        offer(8'hE7);
        spi_frame(8, 32'h0000005A, m);
        tests_run++;
        if (m[7:0] !== 8'hE7 || rx_data !== 8'h5A) begin
            tests_failed++;
            $display("FAIL reset_mid_next: got miso %h rx %h expected e7 5a", m[7:0], rx_data);
        end
    endtask

    task automatic test_cs_high;
        logic [31:0] m;
        int tot0 = fs_cnt + fe_cnt + rv_cnt + ur_cnt + oe_cnt;
        for (int i = 0; i < 10; i++) begin
            sdi = i[0];
            sck = 1'b1;
            wait_clk(4);
            sck = 1'b0;
            wait_clk(4);
        end
        tests_run++;
        if (fs_cnt + fe_cnt + rv_cnt + ur_cnt + oe_cnt - tot0 !== 0) begin
            tests_failed++;
            $display("FAIL cs_high_quiet: got %0d events expected 0", fs_cnt + fe_cnt + rv_cnt + ur_cnt + oe_cnt - tot0);
        end
        offer(8'h55);
        tests_run++;
        if (tx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL cs_high_ready: got %b expected 0", tx_ready);
        end
        offer(8'h66);
        spi_frame(8, 32'h00000000, m);
        tests_run++;
        if (m[7:0] !== 8'h55) begin
            tests_failed++;
            $display("FAIL full_ignore: got %h expected 55", m[7:0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid();
        test_cs_high();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_target.md
# spi_target

SPI mode-0 target (peripheral) byte transceiver: the far end of the SoC's four-wire SPI master (`sck`, `sdo`, `sdi`, `cs`). It oversamples the master's pins in the system clock domain, deserialises MOSI into bytes and serialises bytes from a one-entry transmit holding register onto MISO. It is used as a test companion and as a target-side port for board-level bring-up, attached to spare GPIO pads.

## Interface

Parameters:
- `SYNC_STAGES`, 2: synchroniser flops per SPI input (minimum 2).

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sck`  in  1  SPI clock from the master; idles low (mode 0).
- `cs`  in  1  chip select from the master, active low.
- `sdi`  in  1  MOSI, the master's `sdo`.
- `sdo`  out  1  MISO, to the master's `sdi`.
- `sdo_oe`  out  1  pad output enable for `sdo`; high only while selected.
- `rx_data`  out  8  last complete received byte, MSB first on the wire.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is new.
- `tx_data`  in  8  next byte to send.
- `tx_valid`  in  1  `tx_data` offered.
- `tx_ready`  out  1  holding register empty; a transfer occurs when `tx_valid && tx_ready`.
- `frame_start`  out  1  one-cycle pulse on synchronised `cs` falling.
- `frame_end`  out  1  one-cycle pulse on synchronised `cs` rising.
- `underrun`  out  1  one-cycle pulse; a byte slot was loaded while the holding register was empty.

## Operation

- `sck`, `cs` and `sdi` each pass through `SYNC_STAGES` flops. An extra flop on `sck` and `cs` provides the rise/fall edge detect.
- States: IDLE, ACTIVE.
- IDLE: `sdo_oe`=0, `sdo`=0. On `cs` fall the block enters ACTIVE, pulses `frame_start`, clears `bit_cnt` and performs a byte load.
- Byte load: if the holding register is full, copy it into `tx_shift` and mark it empty. If it is empty, load 0x00 and pulse `underrun`.
- ACTIVE: `sdo_oe`=1 and `sdo` = `tx_shift[7]`.
  - `sck` rise: shift `rx_shift` left with `sdi` and increment `bit_cnt` (3 bits, wraps 7→0).
  - When `bit_cnt` was 7 on that rise: `rx_data` ← {`rx_shift[6:0]`, `sdi`} and `rx_valid` pulses the next cycle.
  - `sck` fall: if `bit_cnt` ≠ 0, shift `tx_shift` left and fill with 0. If `bit_cnt` = 0 (byte boundary), perform a byte load instead.
- `cs` rise in ACTIVE: go to IDLE and pulse `frame_end`.
  - A partial byte (`bit_cnt` ≠ 0) is discarded with no `rx_valid`.
  - The holding register keeps its contents.
- `cs` edges take priority over `sck` edges detected in the same cycle.
- Holding register:
  - `tx_ready` = empty.
  - A handshake and a byte load in the same cycle: the load takes the old contents (or underruns if empty) and the register is refilled with `tx_data`.
  - A new `tx_valid` while full is ignored (not accepted).

## Timing

- Reset values: `sdo`=0, `sdo_oe`=0, `rx_data`=0x00, `rx_valid`=0, `tx_ready`=1, `frame_start`=0, `frame_end`=0, `underrun`=0. State is IDLE, all shift registers and `bit_cnt` are 0, and the holding register is empty.
- Reset applied mid-frame aborts immediately with no pulses. After release, the block waits for a fresh `cs` fall and ignores a `cs` that is already low.
- Edge detect latency is `SYNC_STAGES`+1 `clk` cycles from a pin edge.
- `sdo` updates 1 cycle after the detected `sck` fall, so `SYNC_STAGES`+2 cycles after the pin edge.
- `rx_valid` pulses `SYNC_STAGES`+2 cycles after the eighth `sck` rise.
- Required: `sck` high and low times are each ≥ 4 `clk` periods, so f_sck ≤ f_clk/8.
- Required: at least 4 `clk` periods from `cs` fall to the first `sck` rise, so the first bit is valid.
- `frame_start`, `frame_end`, `rx_valid` and `underrun` are each high for exactly one cycle.

## Structure

- Package `spi_target_pkg`: `state_t` enum {IDLE, ACTIVE} and constant `BYTE_W` = 8.
- Sub-module `spi_target_sync`: a `SYNC_STAGES` synchroniser with registered previous value, outputs `q`, `rise` and `fall`. It is instantiated for `sck` and `cs`; `sdi` uses the `q` output only.

## Test plan

- Preload 0xA5, master sends 0x3C in a one-byte frame → master reads 0xA5; `rx_data`=0x3C with a single `rx_valid`; `tx_ready` rises at `frame_start`; one `frame_start` and one `frame_end` pulse.
- Two-byte frame, 0x12 preloaded and 0x34 offered when `tx_ready` rises → master reads 0x12, 0x34; `rx_valid` pulses twice with master bytes 0xDE, 0xAD; no `underrun`.
- Frame with the holding register empty → master reads 0x00 and `underrun` pulses once. The second byte also reads 0x00 with a second pulse.
- `cs` raised after 5 bits of 0xFF → no `rx_valid` and `frame_end` pulses. The next full frame sending 0x81 yields `rx_data`=0x81.
- `reset_n` asserted after 3 bits → all outputs take their reset values immediately and `sdo_oe`=0. After release, the next frame works normally.
- `cs` high throughout with `sck` toggling → `sdo_oe`=0 and no pulses occur. `tx_valid` with 0x55 sets `tx_ready`=0 and a second `tx_valid` is not accepted.
